// File: rtl/rock_drive_if.sv
// rock_drive_if: command strobes from the path-decision stage and the
// resulting actuator drive / status outputs of rock_drive.
interface rock_drive_if #(
   parameter int FREQ_W = 8,
   parameter int AMP_W  = 8
);
   logic              upd;
   logic              Amin;
   logic              Fplus;
   logic              Fmin;
   logic              ERROR;
   logic              resume;
   logic              dir;
   logic              pwm;
   logic [FREQ_W-1:0] freq_o;
   logic [AMP_W-1:0]  amp_o;
   logic              halted;

   modport master (
      output upd, Amin, Fplus, Fmin, ERROR, resume,
      input  dir, pwm, freq_o, amp_o, halted
   );

   modport slave (
      input  upd, Amin, Fplus, Fmin, ERROR, resume,
      output dir, pwm, freq_o, amp_o, halted
   );
endinterface

// File: rtl/rock_drive.sv
// rock_drive: turns per-step Amin/Fplus/Fmin/ERROR decisions into the rocking
// actuator drive. Frequency and amplitude live in saturating registers; the
// swing direction is the MSB of a phase accumulator; pwm is an amplitude-
// proportional duty from a free-running counter. ERROR latches HALT (pwm off,
// phase/counter frozen) until resume arrives with ERROR low.
// PHASE_W must exceed FREQ_W.
// Optional macro ROCK_SOFTSTART_EN: the PWM compare uses an effective
// amplitude that ramps up by at most A_STEP per upd strobe after reset/resume.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_RUN  | normal drive: commands accepted, phase and counter advance
// ST_HALT | fault latched: pwm forced low, phase/counter/dir frozen
module rock_drive #(
   parameter int FREQ_W  = 8,
   parameter int PHASE_W = 16,
   parameter int AMP_W   = 8,
   parameter int F_INIT  = 16,
   parameter int F_MIN   = 1,
   parameter int F_MAX   = 200,
   parameter int F_STEP  = 4,
   parameter int A_MAX   = 255,
   parameter int A_MIN   = 32,
   parameter int A_STEP  = 8
) (
   input logic        clk,
   input logic        reset,
   rock_drive_if.slave bus
);

   localparam logic [FREQ_W-1:0] F_INIT_C = F_INIT[FREQ_W-1:0];
   localparam logic [FREQ_W-1:0] F_MIN_C  = F_MIN[FREQ_W-1:0];
   localparam logic [FREQ_W-1:0] F_MAX_C  = F_MAX[FREQ_W-1:0];
   localparam logic [FREQ_W:0]   F_MIN_W  = F_MIN[FREQ_W:0];
   localparam logic [FREQ_W:0]   F_MAX_W  = F_MAX[FREQ_W:0];
   localparam logic [FREQ_W:0]   F_STEP_W = F_STEP[FREQ_W:0];
   localparam logic [AMP_W-1:0]  A_MAX_C  = A_MAX[AMP_W-1:0];
   localparam logic [AMP_W-1:0]  A_MIN_C  = A_MIN[AMP_W-1:0];
   localparam logic [AMP_W:0]    A_MIN_W  = A_MIN[AMP_W:0];
   localparam logic [AMP_W:0]    A_STEP_W = A_STEP[AMP_W:0];

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [FREQ_W-1:0]  freq_q, freq_d;
   logic [AMP_W-1:0]   amp_q, amp_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [AMP_W-1:0]   cnt_q, cnt_d;
   logic               pwm_q, pwm_d;

   logic               cmd_en;
   logic               leave_halt;
   logic [FREQ_W:0]    freq_up;
   logic [FREQ_W:0]    freq_dn;
   logic [AMP_W:0]     amp_dn;
   logic [AMP_W-1:0]   amp_cmp;

   assign cmd_en = (state_q == ST_RUN) && bus.upd;

   // Saturating frequency/amplitude update; math is one bit wider so the
   // sign/carry bit catches underflow and overflow before clamping.
   always_comb begin
      freq_d  = freq_q;
      amp_d   = amp_q;
      freq_up = {1'b0, freq_q} + F_STEP_W;
      freq_dn = {1'b0, freq_q} - F_STEP_W;
      amp_dn  = {1'b0, amp_q} - A_STEP_W;
      if (cmd_en) begin
         if (bus.Fmin) begin
            if (freq_dn[FREQ_W] || (freq_dn < F_MIN_W)) begin
               freq_d = F_MIN_C;
            end else begin
               freq_d = freq_dn[FREQ_W-1:0];
            end
            amp_d = A_MAX_C;
         end else if (bus.Fplus) begin
            if (freq_up > F_MAX_W) begin
               freq_d = F_MAX_C;
            end else begin
               freq_d = freq_up[FREQ_W-1:0];
            end
         end else if (bus.Amin) begin
            if (amp_dn[AMP_W] || (amp_dn < A_MIN_W)) begin
               amp_d = A_MIN_C;
            end else begin
               amp_d = amp_dn[AMP_W-1:0];
            end
         end
      end
   end

   // RUN/HALT sequencing plus phase, PWM counter and registered pwm compare.
   // The edge that enters HALT still belongs to RUN, but pwm is forced low.
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      cnt_d      = cnt_q;
      pwm_d      = 1'b0;
      leave_halt = 1'b0;
      case (state_q)
         ST_RUN: begin
            phase_d = phase_q + PHASE_W'(freq_q);
            cnt_d   = cnt_q + AMP_W'(1);
            pwm_d   = (cnt_q < amp_cmp);
            if (bus.ERROR) begin
               state_d = ST_HALT;
               pwm_d   = 1'b0;
            end
         end
         ST_HALT: begin
            if (bus.resume && !bus.ERROR) begin
               state_d    = ST_RUN;
               phase_d    = '0;
               cnt_d      = '0;
               leave_halt = 1'b1;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_RUN;
         freq_q  <= F_INIT_C;
         amp_q   <= A_MAX_C;
         phase_q <= '0;
         cnt_q   <= '0;
         pwm_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         freq_q  <= freq_d;
         amp_q   <= amp_d;
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         pwm_q   <= pwm_d;
      end
   end

`ifdef ROCK_SOFTSTART_EN
   logic [AMP_W-1:0] amp_eff_q, amp_eff_d;
   logic [AMP_W:0]   eff_up;

   // Effective amplitude ramps toward amp by A_STEP per strobe, but drops
   // to amp at once so a reduction is never delayed.
   always_comb begin
      amp_eff_d = amp_eff_q;
      eff_up    = {1'b0, amp_eff_q} + A_STEP_W;
      if (leave_halt) begin
         amp_eff_d = '0;
      end else if (cmd_en) begin
         if (amp_d < amp_eff_q) begin
            amp_eff_d = amp_d;
         end else if (eff_up >= {1'b0, amp_d}) begin
            amp_eff_d = amp_d;
         end else begin
            amp_eff_d = eff_up[AMP_W-1:0];
         end
      end
   end

   // Effective amplitude register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         amp_eff_q <= '0;
      end else begin
         amp_eff_q <= amp_eff_d;
      end
   end

   assign amp_cmp = amp_eff_q;
`else
   assign amp_cmp = amp_q;
   logic unused_leave_halt;
   assign unused_leave_halt = leave_halt;
`endif

   assign bus.dir    = phase_q[PHASE_W-1];
   assign bus.pwm    = pwm_q;
   assign bus.freq_o = freq_q;
   assign bus.amp_o  = amp_q;
   assign bus.halted = (state_q == ST_HALT);

endmodule
